glyph_map_writer: RTL and testbench

- Shared write sequencer for the background glyph map (20x15 cells, 6-bit glyph ids).
- Two requesters (port 0 = CPU, port 1 = game logic) each submit rectangle-fill commands; a single-cell write is a 1x1 fill.
- Round-robin arbitration between the ports; the accepted command expands into one map write per cell.
- Drives the background controller's write_glyph/addr/glyph_id port, optionally only during vertical blank.

---
 rtl/glyph_map_writer.sv | 218 +++++++++++++++++++++
 tb/tb_glyph_map_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_map_writer.sv
// glyph_map_writer: two-port round-robin rectangle-fill sequencer that
// expands each accepted command into one background-map write per cell.
module glyph_map_writer #(
  parameter int unsigned MAP_SIZE_X  = 20,
  parameter int unsigned MAP_SIZE_Y  = 15,
  parameter int unsigned ID_SIZE     = 6,
  parameter int unsigned VBLANK_ONLY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vblank,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [4:0]         req0_x,
  input  logic [3:0]         req0_y,
  input  logic [4:0]         req0_w,
  input  logic [3:0]         req0_h,
  input  logic [ID_SIZE-1:0] req0_id,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [4:0]         req1_x,
  input  logic [3:0]         req1_y,
  input  logic [4:0]         req1_w,
  input  logic [3:0]         req1_h,
  input  logic [ID_SIZE-1:0] req1_id,
  output logic               write_glyph,
  output logic [8:0]         addr,
  output logic [ID_SIZE-1:0] glyph_id,
  output logic               busy,
  output logic               done,
  output logic               done_port,
  output logic               err
);

  // Cell counters are one bit wider than the request fields so the far
  // corner of any command (x<=61, y<=29) never wraps into the map.
  localparam int unsigned CX_W   = 6;
  localparam int unsigned CY_W   = 5;
  localparam int unsigned ADDR_W = 9;

  localparam logic [CX_W-1:0] MAP_X_LIM   = CX_W'(MAP_SIZE_X);
  localparam logic [CY_W-1:0] MAP_Y_LIM   = CY_W'(MAP_SIZE_Y);
  localparam logic            GATE_ALWAYS = (VBLANK_ONLY == 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CX_W-1:0]     cx_q, cx_d;
  logic [CY_W-1:0]     cy_q, cy_d;
  logic [CX_W-1:0]     x0_q, x0_d;
  logic [CX_W-1:0]     x_last_q, x_last_d;
  logic [CY_W-1:0]     y_last_q, y_last_d;
  logic [ID_SIZE-1:0]  id_q, id_d;
  logic                last_grant_q, last_grant_d;
  logic                port_q, port_d;
  logic                zero_q, zero_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_SIZE-1:0]  glyph_q, glyph_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                done_port_q, done_port_d;
  logic                err_q, err_d;

  logic                grant_c;
  logic                accept_c;
  logic                gate_c;
  logic                in_map_c;
  logic [4:0]          sel_x_c;
  logic [3:0]          sel_y_c;
  logic [4:0]          sel_w_c;
  logic [3:0]          sel_h_c;
  logic [ID_SIZE-1:0]  sel_id_c;

  // Round-robin grant and combinational handshake; only offered in IDLE.
  always_comb begin
    grant_c    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == IDLE) & ~rst & req0_valid & ~grant_c;
    req1_ready = (state_q == IDLE) & ~rst & req1_valid &  grant_c;
    accept_c   = req0_ready | req1_ready;
    sel_x_c    = grant_c ? req1_x  : req0_x;
    sel_y_c    = grant_c ? req1_y  : req0_y;
    sel_w_c    = grant_c ? req1_w  : req0_w;
    sel_h_c    = grant_c ? req1_h  : req0_h;
    sel_id_c   = grant_c ? req1_id : req0_id;
    gate_c     = vblank | GATE_ALWAYS;
    in_map_c   = (cx_q < MAP_X_LIM) & (cy_q < MAP_Y_LIM);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x0_d         = x0_q;
    x_last_d     = x_last_q;
    y_last_d     = y_last_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    zero_d       = zero_q;
    write_d      = 1'b0;
    addr_d       = addr_q;
    glyph_d      = glyph_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    done_port_d  = done_port_q;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          x0_d         = CX_W'(sel_x_c);
          cx_d         = CX_W'(sel_x_c);
          cy_d         = CY_W'(sel_y_c);
          x_last_d     = CX_W'(sel_x_c) + CX_W'(sel_w_c) - CX_W'(1);
          y_last_d     = CY_W'(sel_y_c) + CY_W'(sel_h_c) - CY_W'(1);
          id_d         = sel_id_c;
          last_grant_d = grant_c;
          port_d       = grant_c;
          busy_d       = 1'b1;
          zero_d       = (sel_w_c == 5'd0) | (sel_h_c == 4'd0);
          state_d      = ((sel_w_c == 5'd0) | (sel_h_c == 4'd0)) ? FINISH : FILL;
        end
      end
      FILL: begin
        if (gate_c) begin
          if (in_map_c) begin
            write_d = 1'b1;
            addr_d  = ADDR_W'(cy_q) * ADDR_W'(MAP_SIZE_X) + ADDR_W'(cx_q);
            glyph_d = id_q;
          end
          if (cx_q == x_last_q) begin
            cx_d = x0_q;
            if (cy_q == y_last_q) begin
              state_d = FINISH;
            end else begin
              cy_d = cy_q + CY_W'(1);
            end
          end else begin
            cx_d = cx_q + CX_W'(1);
          end
        end
      end
      FINISH: begin
        done_d      = 1'b1;
        err_d       = zero_q;
        done_port_d = port_q;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command context, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx_q         <= '0;
      cy_q         <= '0;
      x0_q         <= '0;
      x_last_q     <= '0;
      y_last_q     <= '0;
      id_q         <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      zero_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      glyph_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_port_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x0_q         <= x0_d;
      x_last_q     <= x_last_d;
      y_last_q     <= y_last_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      zero_q       <= zero_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      glyph_q      <= glyph_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_port_q  <= done_port_d;
      err_q        <= err_d;
    end
  end

  assign write_glyph = write_q;
  assign addr        = addr_q;
  assign glyph_id    = glyph_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_port   = done_port_q;
  assign err         = err_q;

endmodule

// File: tb/tb_glyph_map_writer.sv
// Bench for glyph_map_writer: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the fill rules.
module tb_glyph_map_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblank;
  logic       r0v, r1v;
  logic [4:0] r0x, r1x, r0w, r1w;
  logic [3:0] r0y, r1y, r0h, r1h;
  logic [5:0] r0id, r1id;
  logic       req0_ready, req1_ready;
  logic       write_glyph, busy, done, done_port, err;
  logic [8:0] addr;
  logic [5:0] glyph_id;

  glyph_map_writer dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_x(r0x), .req0_y(r0y),
    .req0_w(r0w), .req0_h(r0h), .req0_id(r0id),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_x(r1x), .req1_y(r1y),
    .req1_w(r1w), .req1_h(r1h), .req1_id(r1id),
    .write_glyph(write_glyph), .addr(addr), .glyph_id(glyph_id),
    .busy(busy), .done(done), .done_port(done_port), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  int q_x[$];
  int q_y[$];
  int m_ph, m_last, m_port, m_zero, m_id;
  int g, px, py, pw, ph, cxv, cyv;
  logic e_write, e_busy, e_done, e_err;
  int e_addr, e_id, e_dport;

  initial begin
    m_ph = 0; m_last = 1; m_port = 0; m_zero = 0; m_id = 0;
    e_write = 0; e_busy = 0; e_done = 0; e_err = 0; e_addr = 0; e_id = 0; e_dport = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = 0; m_last = 1; q_x.delete(); q_y.delete();
        e_write = 0; e_busy = 0; e_done = 0; e_err = 0;
      end else begin
        e_write = 0; e_done = 0; e_err = 0;
        if (m_ph == 0) begin
          g = -1;
          if (r0v && r1v) g = (m_last == 1) ? 0 : 1;
          else if (r0v) g = 0;
          else if (r1v) g = 1;
          if (g >= 0) begin
            px = (g == 0) ? int'(r0x) : int'(r1x);
            py = (g == 0) ? int'(r0y) : int'(r1y);
            pw = (g == 0) ? int'(r0w) : int'(r1w);
            ph = (g == 0) ? int'(r0h) : int'(r1h);
            m_id = (g == 0) ? int'(r0id) : int'(r1id);
            q_x.delete(); q_y.delete();
            for (int j = 0; j < ph; j++)
              for (int i = 0; i < pw; i++) begin
                q_x.push_back(px + i);
                q_y.push_back(py + j);
              end
            m_last = g; m_port = g;
            m_zero = (q_x.size() == 0) ? 1 : 0;
            e_busy = 1;
            m_ph = m_zero ? 2 : 1;
          end
        end else if (m_ph == 1) begin
          if (vblank) begin
            cxv = q_x.pop_front();
            cyv = q_y.pop_front();
            if (cxv < 20 && cyv < 15) begin
              e_write = 1; e_addr = cyv * 20 + cxv; e_id = m_id;
            end
            if (q_x.size() == 0) m_ph = 2;
          end
        end else begin
          e_done = 1; e_err = (m_zero != 0); e_dport = m_port; e_busy = 0; m_ph = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit er0, er1;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      er0 = (m_ph == 0) && r0v && (!r1v || m_last == 1);
      er1 = (m_ph == 0) && r1v && (!r0v || m_last == 0);
      chk("req0_ready", int'(req0_ready), int'(er0));
      chk("req1_ready", int'(req1_ready), int'(er1));
      chk("write_glyph", int'(write_glyph), int'(e_write));
      chk("busy", int'(busy), int'(e_busy));
      chk("done", int'(done), int'(e_done));
      chk("err", int'(err), int'(e_err));
      if (e_write) begin
        chk("addr", int'(addr), e_addr);
        chk("glyph_id", int'(glyph_id), e_id);
      end
      if (e_done) chk("done_port", int'(done_port), e_dport);
    end
  end

  // ---------------- event log for directed checks ----------------
  int acc_p[$], acc_c[$], wr_a[$], wr_i[$], wr_c[$], dn_c[$], dn_p[$], er_c[$];
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (req0_ready && r0v) begin acc_p.push_back(0); acc_c.push_back(cyc); end
      if (req1_ready && r1v) begin acc_p.push_back(1); acc_c.push_back(cyc); end
      if (write_glyph) begin
        wr_a.push_back(int'(addr)); wr_i.push_back(int'(glyph_id)); wr_c.push_back(cyc);
      end
      if (done) begin dn_c.push_back(cyc); dn_p.push_back(int'(done_port)); end
      if (err) er_c.push_back(cyc);
    end
  end

  // ---------------- stimulus ----------------
  int vmode = 0;
  int vph = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (vmode == 0) vblank = 1'b1;
    else if (vmode == 1) begin vph = (vph + 1) % 4; vblank = (vph == 0); end
    else vblank = 1'($urandom_range(0, 1));
  endtask

  task automatic set_port(input int p, input int x, input int y, input int w,
                          input int h, input int id, input logic v);
    if (p == 0) begin
      r0x = 5'(x); r0y = 4'(y); r0w = 5'(w); r0h = 4'(h); r0id = 6'(id); r0v = v;
    end else begin
      r1x = 5'(x); r1y = 4'(y); r1w = 5'(w); r1h = 4'(h); r1id = 6'(id); r1v = v;
    end
  endtask

  task automatic send(input int p, input int x, input int y, input int w,
                      input int h, input int id, output int a_idx);
    int base;
    int dbase;
    base = acc_p.size();
    dbase = dn_c.size();
    a_idx = base;
    set_port(p, x, y, w, h, id, 1'b1);
    for (int k = 0; k < 100 && acc_p.size() == base; k++) tick();
    if (acc_p.size() == base) chk("accept_timeout", 0, 1);
    set_port(p, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 63)), 1'b0);
    for (int k = 0; k < 2000 && dn_c.size() == dbase; k++) tick();
    if (dn_c.size() == dbase) chk("done_timeout", 0, 1);
    tick();
  endtask

  int a, wb, db, eb, ab;
  int exp_fill[4] = '{278, 279, 298, 299};
  int exp_vb[4]   = '{125, 126, 145, 146};

  initial begin
    vblank = 1'b1;
    set_port(0, 3, 2, 1, 1, 21, 1'b1);
    set_port(1, 0, 0, 0, 0, 0, 1'b0);
    tick(); tick(); tick();
    // reset state, with a valid request pending
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_write_glyph", int'(write_glyph), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_glyph_id", int'(glyph_id), 0);
    r0v = 1'b0;
    rst = 1'b0;
    tick();

    // single write
    wb = wr_a.size(); db = dn_c.size();
    send(0, 3, 2, 1, 1, 21, a);
    chk("single_count", wr_a.size() - wb, 1);
    chk("single_addr", wr_a[wb], 43);
    chk("single_id", wr_i[wb], 21);
    chk("single_latency", wr_c[wb] - acc_c[a], 2);
    chk("single_done_lat", dn_c[db] - acc_c[a], 3);
    chk("single_done_port", dn_p[db], 0);

    // clipped fill at the map corner
    wb = wr_a.size(); db = dn_c.size();
    send(1, 18, 13, 4, 3, 7, a);
    chk("fill_count", wr_a.size() - wb, 4);
    for (int k = 0; k < 4; k++) chk("fill_addr", wr_a[wb + k], exp_fill[k]);
    chk("fill_done_lat", dn_c[db] - acc_c[a], 14);
    chk("fill_done_port", dn_p[db], 1);

    // vblank gating: 1 cycle open, 3 closed
    vmode = 1; vph = 0;
    wb = wr_a.size();
    send(0, 5, 6, 2, 2, 9, a);
    vmode = 0;
    chk("vb_count", wr_a.size() - wb, 4);
    for (int k = 0; k < 4; k++) chk("vb_addr", wr_a[wb + k], exp_vb[k]);

    // zero-size command
    wb = wr_a.size(); db = dn_c.size(); eb = er_c.size();
    send(1, 4, 4, 0, 3, 1, a);
    chk("zero_writes", wr_a.size() - wb, 0);
    chk("zero_err_count", er_c.size() - eb, 1);
    chk("zero_err_lat", er_c[eb] - acc_c[a], 2);
    chk("zero_done_lat", dn_c[db] - acc_c[a], 2);

    // reset in the middle of a 4x4 fill
    wb = wr_a.size(); ab = acc_p.size();
    set_port(0, 0, 0, 4, 4, 5, 1'b1);
    for (int k = 0; k < 100 && acc_p.size() == ab; k++) tick();
    r0v = 1'b0;
    for (int k = 0; k < 100 && wr_a.size() < wb + 5; k++) begin
      @(negedge clk);
      #1;
    end
    db = dn_c.size();
    rst = 1'b1;
    #1;
    chk("midrst_write_glyph", int'(write_glyph), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_addr", int'(addr), 0);
    chk("midrst_glyph_id", int'(glyph_id), 0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("midrst_no_done", dn_c.size() - db, 0);
    wb = wr_a.size();
    send(0, 1, 1, 2, 1, 3, a);
    chk("post_rst_count", wr_a.size() - wb, 2);
    chk("post_rst_addr0", wr_a[wb], 21);
    chk("post_rst_addr1", wr_a[wb + 1], 22);

    // contention right after reset: grants alternate starting with port 0
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    ab = acc_p.size(); db = dn_c.size();
    set_port(0, 2, 2, 1, 1, 10, 1'b1);
    set_port(1, 7, 7, 1, 1, 11, 1'b1);
    for (int k = 0; k < 200 && acc_p.size() < ab + 4; k++) tick();
    r0v = 1'b0; r1v = 1'b0;
    for (int k = 0; k < 50 && dn_c.size() < db + 4; k++) tick();
    chk("contend_accepts", acc_p.size() - ab, 4);
    for (int k = 0; k < 4; k++)
      if (ab + k < acc_p.size()) chk("contend_order", acc_p[ab + k], k % 2);

    // randomized traffic, fields change freely while busy
    vmode = 2;
    for (int k = 0; k < 3000; k++) begin
      tick();
      set_port(0, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
               int'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0));
      set_port(1, int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 5)),
               ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
               int'($urandom_range(0, 63)), 1'($urandom_range(0, 3) == 0));
    end
    r0v = 1'b0; r1v = 1'b0;
    for (int k = 0; k < 3000 && (m_ph != 0 || busy); k++) tick();
    chk("drain_idle", int'(busy), 0);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
